// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding RV32 byte-addressed data-memory initiator.
// Sub-word stores do a read-modify-write because the memory always writes a full word.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned F3W = 3;
  localparam int unsigned HW  = 16;

  typedef enum logic [2:0] {IDLE, LOAD, MERGE, WRITE, RESP} state_t;

  state_t         state_q, state_d;
  logic [F3W-1:0] f3_q, f3_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [HW-1:0]  wdata_q, wdata_d;
  logic           req_ready_q, req_ready_d;
  logic           resp_valid_q, resp_valid_d;
  logic [DW-1:0]  resp_rdata_q, resp_rdata_d;
  logic           resp_err_q, resp_err_d;
  logic [AW-1:0]  mem_addr_q, mem_addr_d;
  logic           mem_wen_q, mem_wen_d;
  logic [DW-1:0]  mem_wdata_q, mem_wdata_d;

  logic [DW-1:0]  le;
  logic [AW:0]    end_addr;
  logic           range_err;
  logic           f3_ok;

  // Memory returns B[a] in the top byte; flip to little-endian word order.
  assign le        = {mem_rdata[7:0], mem_rdata[15:8], mem_rdata[23:16], mem_rdata[31:24]};
  assign end_addr  = {1'b0, req_addr} + (AW+1)'(3);
  assign range_err = end_addr >= (AW+1)'(MEM_BYTES);

  always_comb begin
    f3_ok = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = !req_we;
      default:                f3_ok = 1'b0;
    endcase
  end

  // Next state plus next values of every registered output.
  always_comb begin
    state_d      = state_q;
    f3_d         = f3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;
    mem_addr_d   = '0;
    mem_wen_d    = 1'b0;
    mem_wdata_d  = '0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata[HW-1:0];
          if (range_err || !f3_ok) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (!req_we) begin
            state_d    = LOAD;
            mem_addr_d = req_addr;
          end else if (req_funct3 == 3'b010) begin
            state_d     = WRITE;
            mem_addr_d  = req_addr;
            mem_wen_d   = 1'b1;
            mem_wdata_d = req_wdata;
          end else begin
            state_d    = MERGE;
            mem_addr_d = req_addr;
          end
        end
      end
      LOAD: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        case (f3_q)
          3'b000:  resp_rdata_d = {{24{le[7]}}, le[7:0]};
          3'b001:  resp_rdata_d = {{16{le[15]}}, le[15:0]};
          3'b010:  resp_rdata_d = le;
          3'b100:  resp_rdata_d = {24'd0, le[7:0]};
          3'b101:  resp_rdata_d = {16'd0, le[15:0]};
          default: resp_rdata_d = '0;
        endcase
      end
      MERGE: begin
        state_d    = WRITE;
        mem_addr_d = addr_q;
        mem_wen_d  = 1'b1;
        if (f3_q[0]) mem_wdata_d = {le[31:16], wdata_q};
        else         mem_wdata_d = {le[31:8], wdata_q[7:0]};
      end
      WRITE: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      f3_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_wen_q    <= 1'b0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      f3_q         <= f3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_addr_q   <= mem_addr_d;
      mem_wen_q    <= mem_wen_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wen    = mem_wen_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: driver queues expected responses,
// a negedge monitor pops and compares data, error flag and latency.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [7:0]  mem [64];
  logic        pre;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   wen_cnt = 0;

  load_store_unit #(.MEM_BYTES(64)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wen    (mem_wen),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clock = ~clock;

  // Byte memory: combinational big-endian-ordered read, word write with byte k at bits 8k.
  always_comb begin
    mem_rdata = '0;
    for (int k = 0; k < 4; k++)
      if (({1'b0, mem_addr} + 33'(k)) < 33'd64)
        mem_rdata[31-8*k -: 8] = mem[6'(mem_addr + 32'(k))];
  end

  always @(posedge clock) begin
    if (pre) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
      mem[0] <= 8'hDD; mem[1] <= 8'h00; mem[2] <= 8'h02; mem[3] <= 8'h37;
      mem[4] <= 8'h03; mem[5] <= 8'h32; mem[6] <= 8'h02; mem[7] <= 8'h13;
    end else if (mem_wen) begin
      for (int k = 0; k < 4; k++)
        if (({1'b0, mem_addr} + 33'(k)) < 33'd64)
          mem[6'(mem_addr + 32'(k))] <= mem_wdata[8*k +: 8];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial forever begin
    @(negedge clock);
    if (mem_wen === 1'b1) wen_cnt++;
  end

  // Monitor: every response pulse must match the oldest outstanding expectation.
  initial forever begin
    @(negedge clock);
    if (reset_n === 1'b1 && resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        check("resp_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] erd, input logic eerr,
                       input int elat, input bit push);
    int n;
    exp_t e;
    n = 0;
    @(negedge clock);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (req_ready !== 1'b1) check("req_ready_timeout", {31'd0, req_ready}, 32'd1);
    e.rdata = erd; e.err = eerr; e.lat = elat; e.acc = cyc + 1;
    if (push) exp_q.push_back(e);
    @(posedge clock);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    if (exp_q.size() != 0) begin
      check("resp_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    check({tag, "_resp_err"}, {31'd0, resp_err}, 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_wen"}, {31'd0, mem_wen}, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    int w0;
    reset_n = 1'b0; pre = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_idle_outputs("reset");
    pre = 1'b0;
    reset_n = 1'b1;

    // Loads from the preloaded image
    issue(1'b0, 3'b010, 32'h0, 32'h0, 32'h370200DD, 1'b0, 2, 1'b1);
    issue(1'b0, 3'b000, 32'h0, 32'h0, 32'hFFFFFFDD, 1'b0, 2, 1'b1);
    issue(1'b0, 3'b100, 32'h0, 32'h0, 32'h000000DD, 1'b0, 2, 1'b1);
    issue(1'b0, 3'b001, 32'h4, 32'h0, 32'h00003203, 1'b0, 2, 1'b1);
    issue(1'b0, 3'b101, 32'h2, 32'h0, 32'h00003702, 1'b0, 2, 1'b1);
    drain();

    // SB read-modify-write
    w0 = wen_cnt;
    issue(1'b1, 3'b000, 32'h1, 32'h000000AB, 32'h0, 1'b0, 3, 1'b1);
    drain();
    check("sb_wen_pulses", 32'(wen_cnt - w0), 32'd1);
    issue(1'b0, 3'b010, 32'h0, 32'h0, 32'h3702ABDD, 1'b0, 2, 1'b1);
    issue(1'b0, 3'b010, 32'h4, 32'h0, 32'h13023203, 1'b0, 2, 1'b1);
    drain();
    check("sb_b5_kept", {24'd0, mem[5]}, 32'h32);

    // SW full word
    w0 = wen_cnt;
    issue(1'b1, 3'b010, 32'h8, 32'hCAFEF00D, 32'h0, 1'b0, 2, 1'b1);
    drain();
    check("sw_wen_pulses", 32'(wen_cnt - w0), 32'd1);
    check("sw_bytes", {mem[8], mem[9], mem[10], mem[11]}, 32'h0DF0FECA);
    issue(1'b0, 3'b010, 32'h8, 32'h0, 32'hCAFEF00D, 1'b0, 2, 1'b1);

    // SH with sign-bearing halfword, then signed/unsigned reads back
    issue(1'b1, 3'b001, 32'h20, 32'hFFFF8001, 32'h0, 1'b0, 3, 1'b1);
    issue(1'b0, 3'b001, 32'h20, 32'h0, 32'hFFFF8001, 1'b0, 2, 1'b1);
    issue(1'b0, 3'b101, 32'h20, 32'h0, 32'h00008001, 1'b0, 2, 1'b1);
    issue(1'b0, 3'b010, 32'h20, 32'h0, 32'h00008001, 1'b0, 2, 1'b1);
    drain();

    // Range and funct3 errors; highest legal word address
    w0 = wen_cnt;
    issue(1'b0, 3'b010, 32'h3D, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    issue(1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    issue(1'b1, 3'b100, 32'h0, 32'h11223344, 32'h0, 1'b1, 1, 1'b1);
    issue(1'b1, 3'b010, 32'hFFFFFFFE, 32'h11223344, 32'h0, 1'b1, 1, 1'b1);
    issue(1'b0, 3'b010, 32'h3C, 32'h0, 32'h0, 1'b0, 2, 1'b1);
    drain();
    check("err_no_wen", 32'(wen_cnt - w0), 32'd0);
    check("err_mem_intact", {mem[0], mem[1], mem[2], mem[3]}, 32'hDDAB0237);

    // Reset while an SH sits in MERGE
    w0 = wen_cnt;
    issue(1'b1, 3'b001, 32'h10, 32'h00005555, 32'h0, 1'b0, 3, 1'b0);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk_idle_outputs("midreset");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    check("midreset_no_wen", 32'(wen_cnt - w0), 32'd0);
    check("midreset_mem", {mem[16], mem[17], mem[18], mem[19]}, 32'h0);
    issue(1'b0, 3'b010, 32'h0, 32'h0, 32'h3702ABDD, 1'b0, 2, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
